// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// parameter defaults and the button-event priority ordering.
package stopwatch_ctrl_pkg;

  // Default timing: 50 MHz clock, 1 ms tick, 4 ms debounce window.
  localparam int unsigned TICK_DIV_DEF = 50000;
  localparam int unsigned DEB_MS_DEF   = 4;

  // Encoding is visible on the state output and must stay fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  // Winning button event of a cycle.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_CLR   = 3'd1,
    EV_STOP  = 3'd2,
    EV_START = 3'd3,
    EV_LAP   = 3'd4
  } evt_e;

  // Resolve same-cycle events: clr > stop > start > lap.
  function automatic evt_e pick_event(input logic clr, input logic stop,
                                      input logic start, input logic lap);
    if (clr)        return EV_CLR;
    else if (stop)  return EV_STOP;
    else if (start) return EV_START;
    else if (lap)   return EV_LAP;
    else            return EV_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button / digit-chain signal bundle between the stopwatch controller
// (slave side) and the board-level logic driving it (master side).
interface stopwatch_ctrl_if;

  logic       start_btn;
  logic       stop_btn;
  logic       clr_btn;
  logic       lap_btn;
  logic       digit_ovf;
  logic       cnt_en;
  logic       cnt_clr;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  modport master (
    output start_btn, stop_btn, clr_btn, lap_btn, digit_ovf,
    input  cnt_en, cnt_clr, freeze, running, state
  );

  modport slave (
    input  start_btn, stop_btn, clr_btn, lap_btn, digit_ovf,
    output cnt_en, cnt_clr, freeze, running, state
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Per-button conditioning: 2-flop synchronizer, stable-level counter
// stepped by the shared ms tick, and a one-cycle rising-edge event.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_MS = DEB_MS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic tick_i,
  output logic evt_o
);

  localparam int unsigned   CW       = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Level acceptance after DEB_MS agreeing ticks; a button held through
  // reset stays disarmed until a released level has been seen at a tick.
  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
      if (tick_i && !sync2_q) armed_d = 1'b1;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        evt_d   = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with button debouncing and ms count-enable
// generation for an external BCD digit chain.
// Optional lap feature: define STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DEB_MS   = DEB_MS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic [PW-1:0] dpre_q, dpre_d;
  logic [PW-1:0] cpre_q, cpre_d;
  logic          ms_tick;
  logic          start_evt, stop_evt, clr_evt, lap_evt;
  state_e        state_q, state_d;
  logic          freeze_q, freeze_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          run_st;
  evt_e          evt;

  // Free-running debounce prescaler; its wrap is the shared ms tick.
  always_comb begin
    dpre_d = (dpre_q == PRE_LAST) ? '0 : dpre_q + PW'(1);
  end

  assign ms_tick = (dpre_q == PRE_LAST);

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
    .clk(clk), .reset(reset), .btn_i(sw.start_btn), .tick_i(ms_tick), .evt_o(start_evt)
  );
  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_stop (
    .clk(clk), .reset(reset), .btn_i(sw.stop_btn), .tick_i(ms_tick), .evt_o(stop_evt)
  );
  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_clr (
    .clk(clk), .reset(reset), .btn_i(sw.clr_btn), .tick_i(ms_tick), .evt_o(clr_evt)
  );

`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_lap (
    .clk(clk), .reset(reset), .btn_i(sw.lap_btn), .tick_i(ms_tick), .evt_o(lap_evt)
  );
`else
  logic lap_unused;
  assign lap_unused = sw.lap_btn;
  assign lap_evt    = 1'b0;
`endif

  assign run_st = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign evt    = pick_event(clr_evt, stop_evt, start_evt, lap_evt);

  // Next-state logic: clr beats a digit overflow, which beats all other events.
  always_comb begin
    state_d   = state_q;
    freeze_d  = freeze_q;
    cnt_clr_d = 1'b0;
    if (evt == EV_CLR) begin
      state_d   = ST_IDLE;
      freeze_d  = 1'b0;
      cnt_clr_d = 1'b1;
    end else if (run_st && sw.digit_ovf) begin
      state_d = ST_PAUSE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (evt == EV_START) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (evt == EV_STOP) begin
            state_d = ST_PAUSE;
          end else if (evt == EV_LAP) begin
            state_d  = ST_LAP;
            freeze_d = 1'b1;
          end
        end
        ST_LAP: begin
          if (evt == EV_STOP) begin
            state_d = ST_PAUSE;
          end else if (evt == EV_LAP) begin
            state_d  = ST_RUN;
            freeze_d = 1'b0;
          end
        end
        ST_PAUSE: begin
          if (evt == EV_START) begin
            state_d  = ST_RUN;
            freeze_d = 1'b0;
          end else if (evt == EV_LAP) begin
            freeze_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Count prescaler: advances only while counting; a digit_ovf cycle is not
  // counted, so a resumed run starts a full ms from where it stopped.
  always_comb begin
    cpre_d = cpre_q;
    if (cnt_clr_q) begin
      cpre_d = '0;
    end else if (run_st && !sw.digit_ovf) begin
      cpre_d = (cpre_q == PRE_LAST) ? '0 : cpre_q + PW'(1);
    end
  end

  // State, prescaler and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      freeze_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      dpre_q    <= '0;
      cpre_q    <= '0;
    end else begin
      state_q   <= state_d;
      freeze_q  <= freeze_d;
      cnt_clr_q <= cnt_clr_d;
      dpre_q    <= dpre_d;
      cpre_q    <= cpre_d;
    end
  end

  assign sw.cnt_en  = run_st && (cpre_q == PRE_LAST) && !sw.digit_ovf;
  assign sw.cnt_clr = cnt_clr_q;
  assign sw.freeze  = LAP_EN ? freeze_q : 1'b0;
  assign sw.running = run_st;
  assign sw.state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (TICK_DIV=4, DEB_MS=2).
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   n_en;
  int   n_clr;
  int   n_to_run;
  logic seen_pause;
  logic found;
  logic [1:0] prev_st;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_MS(2)) dut (
    .clk(clk), .reset(reset), .sw(sw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sw.cnt_en)  n_en++;
      if (sw.cnt_clr) n_clr++;
      if (sw.state == 2'd1 && prev_st != 2'd1) n_to_run++;
      if (sw.state == 2'd2) seen_pause = 1'b1;
      prev_st = sw.state;
    end
  endtask

  task automatic wait_en(input int bound);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      run(1);
      if (sw.cnt_en) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_run(input int bound);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      run(1);
      if (sw.state == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; n_en = 0; n_clr = 0; n_to_run = 0;
    seen_pause = 1'b0; found = 1'b0; prev_st = 2'd0;
    sw.start_btn = 1'b0; sw.stop_btn = 1'b0; sw.clr_btn = 1'b0;
    sw.lap_btn = 1'b0; sw.digit_ovf = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    run(3);
    check("rst_state",   32'(sw.state),   0);
    check("rst_cnt_en",  32'(sw.cnt_en),  0);
    check("rst_cnt_clr", 32'(sw.cnt_clr), 0);
    check("rst_freeze",  32'(sw.freeze),  0);
    check("rst_running", 32'(sw.running), 0);
    reset = 1'b1;
    run(8);

    // 3-cycle glitch on start: no event.
    n_to_run = 0;
    sw.start_btn = 1'b1; run(3); sw.start_btn = 1'b0; run(12);
    check("glitch_state", 32'(sw.state), 0);
    check("glitch_trans", 32'(n_to_run), 0);

    // start held 12 cycles: one transition to RUN, cnt_en every 4 cycles.
    n_to_run = 0; n_clr = 0;
    sw.start_btn = 1'b1; run(12); sw.start_btn = 1'b0; run(12);
    check("start_state",   32'(sw.state),   1);
    check("start_running", 32'(sw.running), 1);
    check("start_trans",   32'(n_to_run),   1);
    n_en = 0; run(16);
    check("run_en_16",  32'(n_en),  4);
    check("run_no_clr", 32'(n_clr), 0);

    // lap toggles freeze while counting continues.
    n_en = 0;
    sw.lap_btn = 1'b1; run(10); sw.lap_btn = 1'b0; run(14);
    check("lap1_freeze", 32'(sw.freeze), LAP ? 1 : 0);
    check("lap1_state",  32'(sw.state),  LAP ? 3 : 1);
    check("lap1_en_24",  32'(n_en),      6);
    check("lap1_run",    32'(sw.running), 1);
    sw.lap_btn = 1'b1; run(10); sw.lap_btn = 1'b0; run(14);
    check("lap2_freeze", 32'(sw.freeze), 0);
    check("lap2_state",  32'(sw.state),  1);

    // digit_ovf one cycle after a cnt_en (prescaler at 0) forces PAUSE.
    wait_en(8);
    check("ovf_en_seen", 32'(found), 1);
    run(1);
    sw.digit_ovf = 1'b1;
    run(1);
    sw.digit_ovf = 1'b0;
    check("ovf_state",   32'(sw.state),   2);
    check("ovf_running", 32'(sw.running), 0);
    n_en = 0; run(12);
    check("ovf_no_en", 32'(n_en), 0);

    // Resume: cnt_en on the 4th cycle in RUN.
    sw.start_btn = 1'b1;
    wait_run(30);
    check("resume_seen", 32'(found), 1);
    check("resume_en0", 32'(sw.cnt_en), 0);
    run(1); check("resume_en1", 32'(sw.cnt_en), 0);
    run(1); check("resume_en2", 32'(sw.cnt_en), 0);
    run(1); check("resume_en3", 32'(sw.cnt_en), 1);
    sw.start_btn = 1'b0; run(20);

    // stop + clr together in RUN: clr wins, single cnt_clr, no PAUSE.
    n_clr = 0; seen_pause = 1'b0;
    sw.stop_btn = 1'b1; sw.clr_btn = 1'b1; run(10);
    sw.stop_btn = 1'b0; sw.clr_btn = 1'b0; run(14);
    check("sc_state",  32'(sw.state),   0);
    check("sc_clr",    32'(n_clr),      1);
    check("sc_pause",  32'(seen_pause), 0);
    check("sc_freeze", 32'(sw.freeze),  0);

    // clr in IDLE: cnt_clr pulse, stay IDLE.
    n_clr = 0;
    sw.clr_btn = 1'b1; run(10); sw.clr_btn = 1'b0; run(14);
    check("idle_clr",   32'(n_clr),    1);
    check("idle_state", 32'(sw.state), 0);

    // Reset mid-RUN with start held across release.
    sw.start_btn = 1'b1; run(10); sw.start_btn = 1'b0; run(14);
    check("rr_state", 32'(sw.state), 1);
    wait_en(8);
    check("rr_en_seen", 32'(found), 1);
    sw.start_btn = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("arst_state",   32'(sw.state),   0);
    check("arst_running", 32'(sw.running), 0);
    check("arst_cnt_en",  32'(sw.cnt_en),  0);
    check("arst_cnt_clr", 32'(sw.cnt_clr), 0);
    check("arst_freeze",  32'(sw.freeze),  0);
    run(3);
    reset = 1'b1;
    n_to_run = 0;
    run(24);
    check("held_state", 32'(sw.state), 0);
    check("held_trans", 32'(n_to_run), 0);
    sw.start_btn = 1'b0; run(20);
    sw.start_btn = 1'b1;
    wait_run(30);
    sw.start_btn = 1'b0;
    check("repress_state", 32'(sw.state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per 1 ms tick (50 MHz board clock).
REQ-002 Parameter DEB_MS, default 4, consecutive stable ms ticks required to accept a button level.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately; deassertion is synchronous to clk.
REQ-005 start_btn, stop_btn, clr_btn, lap_btn  input  1 each  raw, asynchronous, active-high push-buttons.
REQ-006 digit_ovf  input  1  one-cycle carry-out of the most-significant BCD digit (9999 -> 0000).
REQ-007 cnt_en  output  1  one-cycle pulse per elapsed ms while counting; drives the BCD digit chain.
REQ-008 cnt_clr  output  1  one-cycle synchronous clear pulse for the digit chain.
REQ-009 freeze  output  1  level; 1 = display holds the last latched value (lap view).
REQ-010 running  output  1  level; 1 in RUN or LAP.
REQ-011 state  output  2  current FSM state encoding.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer accepting a new level only after DEB_MS consecutive ms-prescaler wraps with the same synchronized level.
REQ-013 Each debounced rising edge SHALL produce exactly one one-cycle event; held buttons SHALL NOT repeat.
REQ-014 The debounce prescaler SHALL run continuously (0..TICK_DIV-1, wrapping) independently of FSM state.
REQ-015 The count prescaler SHALL count 0..TICK_DIV-1 only in RUN/LAP; it SHALL hold in IDLE/PAUSE and reset to 0 on cnt_clr.
REQ-016 cnt_en SHALL pulse for one cycle when the count prescaler equals TICK_DIV-1 in RUN/LAP.
REQ-017 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-018 IDLE: start -> RUN; all other events ignored, except clr, which pulses cnt_clr.
REQ-019 RUN: stop -> PAUSE; lap -> LAP with freeze=1; clr -> IDLE with cnt_clr.
REQ-020 LAP: lap -> RUN with freeze=0; stop -> PAUSE with freeze kept at 1; clr -> IDLE with cnt_clr and freeze=0.
REQ-021 PAUSE: start -> RUN with freeze=0; lap -> freeze=0 while remaining in PAUSE; clr -> IDLE with cnt_clr.
REQ-022 Simultaneous events in one cycle SHALL be prioritized clr > stop > start > lap; only the winner acts.
REQ-023 digit_ovf in RUN/LAP SHALL force PAUSE on the next cycle; cnt_en SHALL be suppressed from that cycle onward.
REQ-024 clr SHALL take precedence over a same-cycle digit_ovf.
REQ-025 Latency: event cycle N -> state/freeze/cnt_clr change visible at cycle N+1; cnt_clr SHALL be exactly one cycle wide.

Reset
REQ-026 While reset=0: state=IDLE, cnt_en=0, cnt_clr=0, freeze=0, running=0, both prescalers=0, synchronizers and debounced levels=0.
REQ-027 A button held through reset release SHALL generate no event until it is released and pressed again.
REQ-028 Reset asserted mid-RUN SHALL abort counting within the same cycle (asynchronous), without generating a cnt_clr pulse.

Configuration
REQ-029 Macro STOPWATCH_LAP_EN defined: lap_btn and the LAP state are active as specified above.
REQ-030 Macro STOPWATCH_LAP_EN undefined: no lap_btn debouncer is built, lap_btn is ignored, LAP is unreachable, and freeze is constant 0; all other behaviour is unchanged.

Structure
REQ-031 A shared package SHALL hold the state encoding constants, the TICK_DIV/DEB_MS defaults and the event-priority ordering.
REQ-032 Debouncing SHALL be a sub-module btn_debounce (synchronizer, stable counter, rising-edge pulse), instantiated once per button.

Verification (TICK_DIV=4, DEB_MS=2)
REQ-033 start held 12 cycles from IDLE -> exactly one transition to RUN; cnt_en pulses every 4 cycles; running=1.
REQ-034 start glitch of 3 cycles -> no event; state stays IDLE.
REQ-035 RUN, stop and clr pressed on the same cycle -> IDLE; one cnt_clr pulse; no PAUSE.
REQ-036 RUN, lap -> freeze=1 with cnt_en continuing; lap again -> freeze=0; with the macro undefined -> freeze stays 0.
REQ-037 RUN, digit_ovf pulse -> PAUSE next cycle; no further cnt_en; start -> RUN, and the first cnt_en arrives 4 cycles after the transition.
REQ-038 reset pulled low mid-RUN -> all outputs 0 immediately; start held across release -> no RUN until re-pressed.
